prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side counterpart of the LFSR pseudo-random generator. Accepts WIDTH-bit
//  LFSR state words, self-synchronises to the sequence and counts mismatches.
//  Used to loop generator output back into the fabric for BER-style self-test,
//  with err_count feeding the 7-segment display mux as BCD-less hex nibbles.
// PARAMETERS
//  WIDTH      8   word/LFSR width; legal values 4, 8, 16 (else elaboration $error)
//  LOCK_CNT   4   consecutive matches required to declare lock (>=1)
//  UNLOCK_CNT 3   consecutive mismatches while locked that drop lock (>=1)
//  CNT_W      16  width of err_count and word_count
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      asynchronous reset, active-low
//  clr         in   1      sync clear of counters and FSM (same effect as reset)
//  in_valid    in   1      in_data is a new LFSR step this cycle
//  in_data     in   WIDTH  received LFSR state word
//  locked      out  1      checker synchronised to sequence
//  err_pulse   out  1      one-cycle strobe: mismatch detected while locked
//  err_count   out  CNT_W  saturating count of mismatched words while locked
//  word_count  out  CNT_W  saturating count of valid words checked while locked
// BEHAVIOUR
//  - Reset (rst_n=0, async) or clr=1 (sync): state=SEARCH, pred=0, locked=0,
//    err_pulse=0, err_count=0, word_count=0, match/miss counters=0. clr has priority
//    over in_valid in the same cycle.
//  - Polynomial (Fibonacci, shift toward MSB): next(s) = {s[W-2:0], ^(s & TAPS)}.
//    TAPS: W=4 -> 4'b1100; W=8 -> 8'hB8; W=16 -> 16'hD008. Must match generator.
//  - Only cycles with in_valid=1 advance anything; in_valid=0 holds all state.
//  - SEARCH: on valid word d: if d==0 ignore (lockup state); else pred<=next(d),
//    match_cnt<=0, go CHECK.
//  - CHECK: on valid d: if d==pred: pred<=next(d), match_cnt++; when match_cnt
//    reaches LOCK_CNT-1 and this word matches -> LOCKED (locked=1 next cycle).
//    If d!=pred: reseed from d (pred<=next(d), match_cnt<=0, stay CHECK; d==0 ->
//    SEARCH).
//  - LOCKED: on valid d: word_count++ (sat). Match: pred<=next(d), miss_cnt<=0.
//    Mismatch: err_pulse=1 next cycle, err_count++ (sat at 2^CNT_W-1),
//    pred<=next(pred) (free-run, single-bit errors do not resync), miss_cnt++;
//    at UNLOCK_CNT consecutive misses -> SEARCH, locked=0 next cycle; counters hold.
//  - Latency: comparison registered; locked/err_pulse/counters update the cycle
//    after the qualifying in_valid word.
//  - Counters never wrap; they hold at all-ones until clr/reset.
//  - Words received in SEARCH/CHECK never touch err_count/word_count.
// STRUCTURE
//  - Package prbs_pkg: tap constants per width (function prbs_taps(int w)),
//    function lfsr_next(state, taps), state enum typedef {SEARCH, CHECK, LOCKED};
//    the generator lfsr module imports the same package so polynomials stay identical.
//  - One sub-module: sat_counter #(CNT_W) (inc, clr, q) instanced for err_count and
//    word_count. FSM, pred register and match/miss counters live in prbs_checker.
// TESTING (WIDTH=8, LOCK_CNT=4, UNLOCK_CNT=3; seq from 8'h01: 01,02,04,08,11,23,47,8E)
//  1 Feed 01,02,04,08,11 on consecutive valids -> locked=1 cycle after word 11;
//    err_count=0, word_count=0.
//  2 Locked, feed 23,FF(bad),8E -> err_pulse one cycle after FF, err_count=1,
//    word_count=3, locked stays 1 (pred free-runs 47 past bad word).
//  3 Locked, feed three wrong words 00,00,00 -> locked=0 after 3rd; err_count=3;
//    counts hold thereafter in SEARCH.
//  4 In SEARCH feed 00 repeatedly -> stays SEARCH, locked=0; then 01,02,04,08,11
//    -> relocks.
//  5 Gaps: interleave in_valid=0 cycles between sequence words -> identical lock
//    timing in valid-word terms, no err_pulse.
//  6 Assert rst_n=0 mid-LOCKED between clock edges -> locked, err_count, word_count
//    drop to 0 immediately (async); clr=1 with in_valid=1 same cycle -> cleared,
//    word ignored.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: tap tables, LFSR step and checker states.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } prbs_state_t;

  function automatic logic [15:0] prbs_taps(input int w);
    logic [15:0] t;
    case (w)
      4:       t = 16'h000C;
      8:       t = 16'h00B8;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  // Fibonacci step, shifting toward the MSB; bits above w are dropped.
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s,
    input logic [15:0] taps,
    input int          w
  );
    logic [15:0] mask;
    logic [15:0] r;
    mask = 16'((17'h1 << w) - 17'h1);
    r    = {s[14:0], ^(s & taps)};
    return r & mask;
  endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-syncs to an LFSR word stream
// and counts mismatched words while locked.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16)) begin : g_bad_width
    $error("prbs_checker: WIDTH must be 4, 8 or 16");
  end
  if (LOCK_CNT < 1 || UNLOCK_CNT < 1) begin : g_bad_cnt
    $error("prbs_checker: LOCK_CNT and UNLOCK_CNT must be >= 1");
  end

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int UW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;
  localparam logic [15:0] TAPS = prbs_taps(WIDTH);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [UW-1:0] MISS_LAST = UW'(UNLOCK_CNT - 1);

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] s);
    return WIDTH'(lfsr_next(16'(s), TAPS, WIDTH));
  endfunction

  prbs_state_t      state;
  logic [WIDTH-1:0] pred;
  logic [MW-1:0]    match_cnt;
  logic [UW-1:0]    miss_cnt;

  logic [WIDTH-1:0] nxt_d;
  logic [WIDTH-1:0] nxt_p;
  logic             hit;
  logic             zero;
  logic             inc_word;
  logic             inc_err;

  assign nxt_d    = nxt(in_data);
  assign nxt_p    = nxt(pred);
  assign hit      = (in_data == pred);
  assign zero     = (in_data == '0);
  assign inc_word = in_valid && (state == LOCKED);
  assign inc_err  = inc_word && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else if (clr) begin
      state     <= SEARCH;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        unique case (state)
          SEARCH: begin
            // All-zero is the LFSR lockup state; never seed from it.
            if (!zero) begin
              pred      <= nxt_d;
              match_cnt <= '0;
              state     <= CHECK;
            end
          end
          CHECK: begin
            if (hit) begin
              pred <= nxt_d;
              if (match_cnt == MATCH_LAST) begin
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b1;
                state     <= LOCKED;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else if (zero) begin
              match_cnt <= '0;
              state     <= SEARCH;
            end else begin
              pred      <= nxt_d;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (hit) begin
              pred     <= nxt_d;
              miss_cnt <= '0;
            end else begin
              // Free-run past bad words so bit errors never resync.
              err_pulse <= 1'b1;
              pred      <= nxt_p;
              if (miss_cnt == MISS_LAST) begin
                miss_cnt <= '0;
                locked   <= 1'b0;
                state    <= SEARCH;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_err),
    .clr   (clr),
    .q     (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_word),
    .clr   (clr),
    .q     (word_count)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker (WIDTH=8, narrow counters
// so saturation is reachable).
module tb_prbs_checker;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       locked;
  logic       err_pulse;
  logic [3:0] err_count;
  logic [3:0] word_count;

  int checks;
  int errors;
  logic [7:0] p;

  prbs_checker #(
    .WIDTH      (8),
    .LOCK_CNT   (4),
    .UNLOCK_CNT (3),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tnext(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic put(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lock_seq();
    put(1, 8'h01); put(1, 8'h02); put(1, 8'h04); put(1, 8'h08);
    chk("pre_lock", locked, 0);
    put(1, 8'h11);
    chk("lock", locked, 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_err", err_count, 0);
    chk("rst_words", word_count, 0);

    // 1: lock after 01,02,04,08,11
    lock_seq();
    chk("t1_err", err_count, 0);
    chk("t1_words", word_count, 0);

    // 2: one bad word, pred free-runs past it
    put(1, 8'h23);
    chk("t2_w1", word_count, 1);
    put(1, 8'hFF);
    chk("t2_pulse", err_pulse, 1);
    chk("t2_err", err_count, 1);
    chk("t2_w2", word_count, 2);
    put(1, 8'h8E);
    chk("t2_pulse_off", err_pulse, 0);
    chk("t2_err_hold", err_count, 1);
    chk("t2_w3", word_count, 3);
    chk("t2_locked", locked, 1);

    // clr with in_valid in same cycle
    clr = 1'b1;
    put(1, 8'h1C);
    clr = 1'b0;
    chk("clr_locked", locked, 0);
    chk("clr_err", err_count, 0);
    chk("clr_words", word_count, 0);

    // 3: three consecutive misses drop lock
    lock_seq();
    put(1, 8'h00); put(1, 8'h00);
    chk("t3_still", locked, 1);
    chk("t3_err2", err_count, 2);
    put(1, 8'h00);
    chk("t3_unlock", locked, 0);
    chk("t3_err3", err_count, 3);
    chk("t3_words", word_count, 3);
    put(1, 8'h23); put(1, 8'h47);
    chk("t3_hold_err", err_count, 3);
    chk("t3_hold_w", word_count, 3);

    // 4: zeros in SEARCH, then relock
    clr = 1'b1; put(0, 8'h00); clr = 1'b0;
    put(1, 8'h00); put(1, 8'h00); put(1, 8'h00);
    chk("t4_search", locked, 0);
    lock_seq();

    // word_count saturation
    p = 8'h23;
    for (int i = 0; i < 20; i++) begin
      put(1, p);
      p = tnext(p);
    end
    chk("sat_words", word_count, 15);
    chk("sat_w_err", err_count, 0);

    // err_count saturation: bad,bad,good groups keep lock
    for (int i = 0; i < 8; i++) begin
      put(1, p ^ 8'h80); p = tnext(p);
      put(1, p ^ 8'h80); p = tnext(p);
      put(1, p);         p = tnext(p);
    end
    chk("sat_err", err_count, 15);
    chk("sat_locked", locked, 1);

    // 5: gaps between valid words
    clr = 1'b1; put(0, 8'h00); clr = 1'b0;
    put(1, 8'h01); put(0, 8'hAA);
    put(1, 8'h02); put(0, 8'hAA);
    put(1, 8'h04); put(0, 8'hAA);
    put(1, 8'h08); put(0, 8'hAA);
    chk("t5_pre", locked, 0);
    put(1, 8'h11);
    chk("t5_lock", locked, 1);
    put(0, 8'h55);
    chk("t5_hold", locked, 1);
    chk("t5_pulse", err_pulse, 0);
    chk("t5_words", word_count, 0);

    // 6: async reset between edges
    put(1, 8'h23); put(1, 8'hFF);
    chk("t6_pre_err", err_count, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_locked", locked, 0);
    chk("t6_err", err_count, 0);
    chk("t6_words", word_count, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
